// File: rtl/tanh_pwl_ctrl.sv
// Piecewise-linear tanh sequencer: classifies |x|, issues |x|*slope+intercept to a shared FMA.
// Optional TANH_SAT_BYPASS_EN: the saturated segment returns +/-1.0 without using the FMA.
module tanh_pwl_ctrl #(
  parameter int unsigned                 FLOAT_WIDTH = 32,
  parameter logic [FLOAT_WIDTH-1:0]      BP0         = 32'h3f400000,
  parameter logic [FLOAT_WIDTH-1:0]      BP1         = 32'h3fc00000,
  parameter logic [FLOAT_WIDTH-1:0]      BP2         = 32'h40300000,
  parameter logic [FLOAT_WIDTH-1:0]      BP3         = 32'h40a00000,
  parameter int unsigned                 TIMEOUT     = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [FLOAT_WIDTH-1:0] x,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FLOAT_WIDTH-1:0] y,
  output logic                   err,
  output logic                   fma_req,
  input  logic                   fma_gnt,
  output logic [FLOAT_WIDTH-1:0] fma_a,
  output logic [FLOAT_WIDTH-1:0] fma_b,
  output logic [FLOAT_WIDTH-1:0] fma_c,
  input  logic                   fma_valid,
  input  logic [FLOAT_WIDTH-1:0] fma_result
);

  localparam int unsigned            CNT_W   = $clog2(TIMEOUT);
  localparam logic [FLOAT_WIDTH-1:0] QNAN    = 32'h7fc00000;
  localparam logic [FLOAT_WIDTH-2:0] ONE_MAG = 31'h3f800000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLASS,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic                   sign_q, sign_d;
  logic [FLOAT_WIDTH-1:0] mag_q, mag_d;
  logic [FLOAT_WIDTH-1:0] slope_q, slope_d;
  logic [FLOAT_WIDTH-1:0] icpt_q, icpt_d;
  logic [FLOAT_WIDTH-1:0] y_q, y_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [2:0]             seg;
  logic [FLOAT_WIDTH-1:0] tbl_slope, tbl_icpt;
  logic                   unused_res_sign;

  assign unused_res_sign = fma_result[FLOAT_WIDTH-1];

  // Positive IEEE values order the same as their unsigned bit patterns.
  always_comb begin
    if (mag_q < BP0)      seg = 3'd0;
    else if (mag_q < BP1) seg = 3'd1;
    else if (mag_q < BP2) seg = 3'd2;
    else if (mag_q < BP3) seg = 3'd3;
    else                  seg = 3'd4;
  end

  always_comb begin
    tbl_slope = '0;
    tbl_icpt  = '0;
    unique case (seg)
      3'd0: begin tbl_slope = 32'h3f58cc2a; tbl_icpt = 32'h00000000; end
      3'd1: begin tbl_slope = 32'h3eb851cc; tbl_icpt = 32'h3ebaf4e5; end
      3'd2: begin tbl_slope = 32'h3d8e116d; tbl_icpt = 32'h3f4d1487; end
      3'd3: begin tbl_slope = 32'h3b6a7545; tbl_icpt = 32'h3f7b65c2; end
      default: begin tbl_slope = 32'h00000000; tbl_icpt = 32'h3f800000; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    slope_d = slope_q;
    icpt_d  = icpt_q;
    y_d     = y_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d = x[FLOAT_WIDTH-1];
          mag_d  = {1'b0, x[FLOAT_WIDTH-2:0]};
          if (x[30:23] == 8'hff) begin
            state_d = S_DONE;
            y_d     = (x[22:0] != '0) ? QNAN : {x[FLOAT_WIDTH-1], ONE_MAG};
          end else begin
            state_d = S_CLASS;
          end
        end
      end
      S_CLASS: begin
        slope_d = tbl_slope;
        icpt_d  = tbl_icpt;
        state_d = S_ISSUE;
`ifdef TANH_SAT_BYPASS_EN
        if (seg == 3'd4) begin
          state_d = S_DONE;
          y_d     = {sign_q, ONE_MAG};
        end
`endif
      end
      S_ISSUE: begin
        if (fma_gnt) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (fma_valid) begin
          y_d     = {sign_q, fma_result[FLOAT_WIDTH-2:0]};
          state_d = S_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          y_d     = QNAN;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      slope_q <= '0;
      icpt_q  <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      slope_q <= slope_d;
      icpt_q  <= icpt_d;
      y_q     <= y_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake outputs are gated by reset so a mid-flight reset drops them at once.
  assign in_ready  = reset && (state_q == S_IDLE);
  assign fma_req   = reset && (state_q == S_ISSUE);
  assign out_valid = reset && (state_q == S_DONE);
  assign y         = y_q;
  assign err       = err_q;
  assign fma_a     = mag_q;
  assign fma_b     = slope_q;
  assign fma_c     = icpt_q;

endmodule

// File: tb/tb_tanh_pwl_ctrl.sv
// Self-checking bench for tanh_pwl_ctrl: real-valued reference model plus a behavioural FMA responder.
module tb_tanh_pwl_ctrl;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready, err;
  logic        fma_req, fma_gnt, fma_valid;
  logic [31:0] x, y, fma_a, fma_b, fma_c, fma_result;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic        err_exp;
  bit          bypass;
  logic [31:0] y_got;

  logic [31:0] SLOPE [5] = '{32'h3f58cc2a, 32'h3eb851cc, 32'h3d8e116d, 32'h3b6a7545, 32'h00000000};
  logic [31:0] ICPT  [5] = '{32'h00000000, 32'h3ebaf4e5, 32'h3f4d1487, 32'h3f7b65c2, 32'h3f800000};

  always #5 clk = ~clk;

  tanh_pwl_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x          (x),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .y          (y),
    .err        (err),
    .fma_req    (fma_req),
    .fma_gnt    (fma_gnt),
    .fma_a      (fma_a),
    .fma_b      (fma_b),
    .fma_c      (fma_c),
    .fma_valid  (fma_valid),
    .fma_result (fma_result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic real pow2(input int n);
    real r;
    r = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
    else        for (int i = 0; i < -n; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    m = real'(b[22:0]);
    e = int'(b[30:23]);
    if (e == 0) e = -149;
    else begin
      m = m + 8388608.0;
      e = e - 150;
    end
    m = m * pow2(e);
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real v);
    logic [63:0] d;
    logic [23:0] m;
    int          e;
    d = $realtobits(v);
    if (v == 0.0) return {d[63], 31'b0};
    e = int'(d[62:52]) - 1023 + 127;
    if (e <= 0) return {d[63], 31'b0};
    m = {1'b0, d[51:29]};
    if (d[28] && ((|d[27:0]) || m[0])) m = m + 24'd1;
    if (m[23]) begin
      e = e + 1;
      m = '0;
    end
    return {d[63], e[7:0], m[22:0]};
  endfunction

  function automatic int ref_seg(input logic [31:0] mag);
    real v;
    v = f2r(mag);
    if (v < 0.75) return 0;
    if (v < 1.5)  return 1;
    if (v < 2.75) return 2;
    if (v < 5.0)  return 3;
    return 4;
  endfunction

  task automatic run_txn(input logic [31:0] xv, input int gd, input int fl, input bit respond,
                         output logic [31:0] yo);
    logic        sgn;
    logic [31:0] mag, eb, ec, ey, res;
    int          sg, lat, wcnt, vcnt, exp_lat, hold;
    bit          saw_req, granted, special, sat;

    sgn     = xv[31];
    mag     = {1'b0, xv[30:0]};
    special = (xv[30:23] == 8'hff);
    sg      = special ? 0 : ref_seg(mag);
    eb      = SLOPE[sg];
    ec      = ICPT[sg];
    sat     = bypass && (sg == 4) && !special;
    res     = '0;
    if (special) begin
      ey      = (xv[22:0] != 23'd0) ? 32'h7fc00000 : {sgn, 31'h3f800000};
      exp_lat = 1;
    end else if (sat) begin
      ey      = {sgn, 31'h3f800000};
      exp_lat = 2;
    end else if (!respond) begin
      ey      = 32'h7fc00000;
      exp_lat = 3 + gd + 64;
    end else begin
      res     = r2f(f2r(mag) * f2r(eb) + f2r(ec));
      ey      = {sgn, res[30:0]};
      exp_lat = 3 + gd + fl;
    end

    for (int i = 0; i < 20 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    check("in_ready", in_ready, 1);
    x = xv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; x = $urandom;
    lat = 1; wcnt = 0; vcnt = 0; saw_req = 0; granted = 0;

    for (int cyc = 0; cyc < 300 && !out_valid; cyc++) begin
      fma_gnt = 1'b0; fma_valid = 1'b0;
      if (fma_req) begin
        saw_req = 1;
        check("fma_a", fma_a, mag);
        check("fma_b", fma_b, eb);
        check("fma_c", fma_c, ec);
        if (wcnt == gd) begin
          fma_gnt = 1'b1;
          res = r2f(f2r(fma_a) * f2r(fma_b) + f2r(fma_c));
        end else wcnt++;
      end
      if (granted && respond) begin
        vcnt++;
        if (vcnt == fl) begin
          fma_valid  = 1'b1;
          fma_result = res;
          fma_result[31] = 1'($urandom_range(0, 1));
        end
      end
      if (fma_gnt) granted = 1;
      @(posedge clk); #1;
      lat++;
    end
    fma_gnt = 1'b0; fma_valid = 1'b0;
    if (!respond && !special && !sat) err_exp = 1'b1;

    check("out_valid", out_valid, 1);
    check("latency", lat, exp_lat);
    check("y", y, ey);
    check("err", err, err_exp);
    check("fma_used", saw_req, !(special || sat));
    yo = y;

    hold = $urandom_range(0, 2);
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0; fma_valid = 1'b1; fma_result = 32'h12345678;
      @(posedge clk); #1;
      fma_valid = 1'b0;
      check("hold_valid", out_valid, 1);
      check("hold_y", y, ey);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("done_clear", out_valid, 0);
    check("ready_after", in_ready, 1);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 10 && !fma_req; i++) begin
      @(posedge clk); #1;
    end
    check("req_seen", fma_req, 1);
  endtask

  initial begin
    logic [31:0] xv;
    int          s, e;
    reset = 1'b0; in_valid = 1'b0; x = '0; out_ready = 1'b0;
    fma_gnt = 1'b0; fma_valid = 1'b0; fma_result = '0; err_exp = 1'b0;
    bypass = 1'b0;
`ifdef TANH_SAT_BYPASS_EN
    bypass = 1'b1;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 0);
    check("rst_err", err, 0);
    check("rst_fma_req", fma_req, 0);
    check("rst_fma_a", fma_a, 0);
    check("rst_fma_b", fma_b, 0);
    check("rst_fma_c", fma_c, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("idle_ready", in_ready, 1);

    run_txn(32'h3f000000, 0, 1, 1, y_got);
    check("y_half", y_got, 32'h3ed8cc2a);
    run_txn(32'hbfc00000, 0, 1, 1, y_got);
    check("y_neg_sign", y_got[31], 1);
    run_txn(32'h41200000, 0, 1, 1, y_got);
    check("y_ten", y_got, 32'h3f800000);
    run_txn(32'h3f800000, 10, 2, 1, y_got);
    run_txn(32'h3f400000, 0, 1, 0, y_got);
    check("y_timeout", y_got, 32'h7fc00000);
    run_txn(32'h7fc00001, 0, 1, 1, y_got);
    run_txn(32'hff800000, 0, 1, 1, y_got);
    check("y_neg_inf", y_got, 32'hbf800000);
    run_txn(32'h7f800000, 0, 1, 1, y_got);
    run_txn(32'h3f3fffff, 0, 1, 1, y_got);
    run_txn(32'h40300000, 1, 1, 1, y_got);
    run_txn(32'hc0a00000, 0, 3, 1, y_got);
    run_txn(32'h00000001, 0, 1, 1, y_got);
    run_txn(32'h80000000, 0, 1, 1, y_got);

    for (int n = 0; n < 24; n++) begin
      s  = $urandom_range(0, 1);
      e  = $urandom_range(100, 131);
      xv = $urandom;
      xv[31]    = s[0];
      xv[30:23] = e[7:0];
      run_txn(xv, $urandom_range(0, 3), $urandom_range(1, 3), 1, y_got);
    end

    x = 32'h3f800000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_req();
    reset = 1'b0; #1;
    check("req_drop", fma_req, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    err_exp = 1'b0;
    check("issue_rst_ready", in_ready, 1);
    check("issue_rst_err", err, 0);

    x = 32'h3fa00000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_req();
    fma_gnt = 1'b1;
    @(posedge clk); #1;
    fma_gnt = 1'b0;
    check("wait_no_req", fma_req, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("wrst_in_ready", in_ready, 0);
    check("wrst_req", fma_req, 0);
    check("wrst_out_valid", out_valid, 0);
    check("wrst_y", y, 0);
    check("wrst_fma_a", fma_a, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("wrst_ready", in_ready, 1);
    fma_valid = 1'b1; fma_result = 32'h3f000000;
    @(posedge clk); #1;
    fma_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("stale_valid", out_valid, 0);
    check("stale_y", y, 0);
    run_txn(32'h00000000, 0, 1, 1, y_got);
    check("y_zero", y_got, 32'h00000000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
